// File: rtl/dac_driver_sync.sv
// Clocked driver stage for the segmented current-steering DAC: registered binary and
// thermometer switch drive with complementary rails, optional DWA rotation and power-up FSM.
module dac_driver_sync #(
  parameter int unsigned NBIN     = 7,
  parameter int unsigned NTHERM   = 17,
  parameter int unsigned WAKE_CYC = 8,
  parameter int unsigned PW       = $clog2(NTHERM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pdb,
  input  logic              dem_en,
  input  logic [NBIN-1:0]   datain,
  input  logic [NTHERM-1:0] datatherm,
  output logic [NBIN-1:0]   databinout,
  output logic [NBIN-1:0]   databinoutb,
  output logic [NTHERM-1:0] datathermout,
  output logic [NTHERM-1:0] datathermoutb,
  output logic              ready,
  output logic [PW-1:0]     dem_ptr
);

  localparam int unsigned LW        = $clog2(NTHERM + 1);
  localparam int unsigned CW        = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam int unsigned WAKE_LAST = (WAKE_CYC > 0) ? WAKE_CYC - 1 : 0;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   wake_cnt;
  logic [CW-1:0]   wake_cnt_next;

  logic [LW-1:0]   level_c;
  logic            s1_valid;
  logic [NBIN-1:0] s1_bin;
  logic [LW-1:0]   s1_level;
  logic            s1_dem;

  logic [NTHERM-1:0] therm_c;
  logic [PW-1:0]     ptr_next_c;
  logic [31:0]       ptr32;
  logic [31:0]       lvl32;
  logic [31:0]       off32;
  logic [31:0]       sum32;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      wake_cnt <= '0;
    end else begin
      state    <= state_next;
      wake_cnt <= wake_cnt_next;
    end
  end

  // Next-state logic; pdb low overrides every state
  always_comb begin
    state_next    = state;
    wake_cnt_next = wake_cnt;
    if (!pdb) begin
      state_next    = OFF;
      wake_cnt_next = '0;
    end else begin
      case (state)
        OFF: begin
          state_next    = (WAKE_CYC == 0) ? RUN : WAKE;
          wake_cnt_next = '0;
        end
        WAKE: begin
          if (wake_cnt == CW'(WAKE_LAST)) begin
            state_next    = RUN;
            wake_cnt_next = '0;
          end else begin
            wake_cnt_next = wake_cnt + CW'(1);
          end
        end
        RUN:     state_next = RUN;
        default: state_next = OFF;
      endcase
    end
  end

  // Popcount of the thermometer input; only the level matters downstream
  always_comb begin
    level_c = '0;
    for (int unsigned i = 0; i < NTHERM; i++) begin
      level_c = level_c + LW'(datatherm[i]);
    end
  end

  // Stage 1: capture only on edges that stay in RUN, otherwise flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_level <= '0;
      s1_dem   <= 1'b0;
    end else if (state == RUN && state_next == RUN) begin
      s1_valid <= 1'b1;
      s1_bin   <= datain;
      s1_level <= level_c;
      s1_dem   <= dem_en;
    end else begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_level <= '0;
      s1_dem   <= 1'b0;
    end
  end

  // Stage 2 decode: direct thermometer or rotated window starting at dem_ptr
  always_comb begin
    ptr32   = 32'(dem_ptr);
    lvl32   = 32'(s1_level);
    off32   = '0;
    therm_c = '0;
    for (int unsigned i = 0; i < NTHERM; i++) begin
      off32 = (i >= ptr32) ? (i - ptr32) : (i + NTHERM - ptr32);
      therm_c[i] = s1_dem ? (off32 < lvl32) : (i < lvl32);
    end
  end

  // Pointer advance: level never exceeds NTHERM, so one subtraction wraps it
  always_comb begin
    sum32 = 32'(dem_ptr) + 32'(s1_level);
    if (sum32 >= NTHERM) begin
      sum32 = sum32 - NTHERM;
    end
    ptr_next_c = PW'(sum32);
  end

  // Output registers follow the state being entered on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      databinout    <= '0;
      databinoutb   <= '0;
      datathermout  <= '0;
      datathermoutb <= '0;
      ready         <= 1'b0;
      dem_ptr       <= '0;
    end else if (state_next == OFF) begin
      databinout    <= '0;
      databinoutb   <= '0;
      datathermout  <= '0;
      datathermoutb <= '0;
      ready         <= 1'b0;
      dem_ptr       <= '0;
    end else if (state_next == RUN && s1_valid) begin
      databinout    <= s1_bin;
      databinoutb   <= ~s1_bin;
      datathermout  <= therm_c;
      datathermoutb <= ~therm_c;
      ready         <= 1'b1;
      if (s1_dem) begin
        dem_ptr <= ptr_next_c;
      end
    end else begin
      // Complementary zero code while waking or while the pipeline refills
      databinout    <= '0;
      databinoutb   <= '1;
      datathermout  <= '0;
      datathermoutb <= '1;
      ready         <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_dac_driver_sync.sv
// Scoreboard bench for dac_driver_sync (NBIN=7, NTHERM=17, WAKE_CYC=4).
module tb_dac_driver_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        pdb;
  logic        dem_en;
  logic [6:0]  datain;
  logic [16:0] datatherm;
  logic [6:0]  databinout;
  logic [6:0]  databinoutb;
  logic [16:0] datathermout;
  logic [16:0] datathermoutb;
  logic        ready;
  logic [4:0]  dem_ptr;

  typedef struct {
    logic [6:0]  bin;
    logic [16:0] therm;
    logic [4:0]  ptr;
  } exp_t;

  exp_t       q[$];
  int         checks;
  int         errors;
  logic [4:0] mptr;

  dac_driver_sync #(.NBIN(7), .NTHERM(17), .WAKE_CYC(4)) dut (
    .clk(clk), .rst(rst), .pdb(pdb), .dem_en(dem_en),
    .datain(datain), .datatherm(datatherm),
    .databinout(databinout), .databinoutb(databinoutb),
    .datathermout(datathermout), .datathermoutb(datathermoutb),
    .ready(ready), .dem_ptr(dem_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model_therm(input int lvl, input int ptr, input bit dem);
    logic [16:0] t;
    t = '0;
    for (int k = 0; k < lvl; k++) begin
      if (dem) t[(ptr + k) % 17] = 1'b1;
      else     t[k] = 1'b1;
    end
    return t;
  endfunction

  // Called at a negedge: compare the sample driven two steps ago, then drive a new one
  task automatic step(input logic [6:0] b, input logic [16:0] t, input bit d);
    exp_t        e;
    int          lvl;
    logic [6:0]  nb;
    logic [16:0] nt;
    if (q.size() == 2) begin
      e  = q.pop_front();
      nb = ~e.bin;
      nt = ~e.therm;
      check("bin",    32'(databinout),    32'(e.bin));
      check("binb",   32'(databinoutb),   32'(nb));
      check("therm",  32'(datathermout),  32'(e.therm));
      check("thermb", 32'(datathermoutb), 32'(nt));
      check("ptr",    32'(dem_ptr),       32'(e.ptr));
      check("ready",  32'(ready),         32'd1);
    end
    datain    = b;
    datatherm = t;
    dem_en    = d;
    lvl       = $countones(t);
    e.bin     = b;
    e.therm   = model_therm(lvl, int'(mptr), d);
    if (d) mptr = 5'((int'(mptr) + lvl) % 17);
    e.ptr = mptr;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge where pdb was raised; expects four WAKE cycles
  task automatic wake_seq();
    int n;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      check("wake_therm",  32'(datathermout),  32'd0);
      check("wake_thermb", 32'(datathermoutb), 32'h1FFFF);
      check("wake_binb",   32'(databinoutb),   32'h7F);
      check("wake_ptr",    32'(dem_ptr),       32'd0);
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    check("wake_len",   32'(n),             32'd4);
    check("hold_thermb", 32'(datathermoutb), 32'h1FFFF);
    check("hold_bin",   32'(databinout),    32'd0);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_bin"},    32'(databinout),    32'd0);
    check({tag, "_binb"},   32'(databinoutb),   32'd0);
    check({tag, "_therm"},  32'(datathermout),  32'd0);
    check({tag, "_thermb"}, 32'(datathermoutb), 32'd0);
    check({tag, "_ready"},  32'(ready),         32'd0);
    check({tag, "_ptr"},    32'(dem_ptr),       32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; mptr = '0;
    rst = 1'b1; pdb = 1'b0; dem_en = 1'b0; datain = '0; datatherm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_off("rst");
    rst = 1'b0;
    @(negedge clk);
    check_off("off_idle");

    pdb = 1'b1;
    wake_seq();

    // Passthrough, DWA wrap, extremes, frozen pointer
    step(7'h55, 17'h00E11, 1'b0);
    step(7'h12, 17'h003FF, 1'b1);
    step(7'h34, 17'h1F01F, 1'b1);
    step(7'h7F, 17'h1FFFF, 1'b1);
    step(7'h00, 17'h00000, 1'b1);
    step(7'h2A, 17'h0F0F0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(7'($urandom_range(0, 127)), 17'($urandom), 1'($urandom));
    end

    // Power-down with two samples in flight
    pdb = 1'b0;
    datain = 7'h66; datatherm = 17'h0FFFF; dem_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_off("pd");
    @(posedge clk);
    @(negedge clk);
    check_off("pd_nostale");
    q.delete();
    mptr = '0;

    pdb = 1'b1;
    wake_seq();
    step(7'h01, 17'h00007, 1'b1);
    step(7'h4C, 17'h000F0, 1'b1);
    step(7'h3B, 17'h10001, 1'b1);
    step(7'h71, 17'h0FF00, 1'b0);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check_off("async_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
